kv_filter_table: RTL and testbench



---
 rtl/kv_filter_table.sv | 121 ++++++++++++
 tb/tb_kv_filter_table.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/kv_filter_table.sv
// kv_filter_table: hash-indexed key/status table that turns DNS-response flows into block verdicts.
// Ports: clk156/eth_rst clock and async reset; in_key/in_flag/in_valid/in_ready lookup request;
// out_valid/out_flag verdict; init_done clear sweep finished; hit_cnt/drop_cnt/evict_cnt statistics.
module kv_filter_table #(
    parameter int KEY_SIZE   = 96,
    parameter int INDEX_BITS = 6
) (
    input  logic                clk156,
    input  logic                eth_rst,
    input  logic [KEY_SIZE-1:0] in_key,
    input  logic [3:0]          in_flag,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    output logic [3:0]          out_flag,
    output logic                init_done,
    output logic [15:0]         hit_cnt,
    output logic [15:0]         drop_cnt,
    output logic [15:0]         evict_cnt
);
    localparam int EW    = KEY_SIZE + 3;
    localparam int NCH   = (KEY_SIZE + INDEX_BITS - 1) / INDEX_BITS;
    localparam int DEPTH = 1 << INDEX_BITS;
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CMP, S_RESP} state_t;
    state_t                    r_state, w_next;
    logic [INDEX_BITS-1:0]     r_sweep, r_idx, w_idx, w_addr;
    logic [NCH*INDEX_BITS-1:0] w_ext;
    logic [KEY_SIZE-1:0]       r_key;
    logic [2:0]                r_flag;
    logic [EW-1:0]             r_mem [DEPTH];
    logic [EW-1:0]             r_rd, r_wdata, w_wdata, w_wd;
    logic                      r_wr, w_wr, w_we, w_hit, w_evict, w_susp, w_arr, w_valid;
    logic [1:0]                w_stat, w_verdict;
    logic [3:0]                r_out_flag;
    logic                      r_init_done;
    logic [15:0]               r_hit, r_drop, r_evict;
    logic                      w_unused;
    assign w_unused  = in_flag[3];
    assign in_ready  = r_state == S_IDLE;
    assign out_valid = r_state == S_RESP;
    assign out_flag  = r_out_flag;
    assign init_done = r_init_done;
    assign hit_cnt   = r_hit;
    assign drop_cnt  = r_drop;
    assign evict_cnt = r_evict;
    // Index is the XOR of all INDEX_BITS-wide chunks of the zero-extended key.
    always_comb begin
        w_ext = '0;
        w_ext[KEY_SIZE-1:0] = in_key;
        w_idx = '0;
        for (int i = 0; i < NCH; i++) w_idx = w_idx ^ w_ext[i*INDEX_BITS +: INDEX_BITS];
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:  w_next = &r_sweep ? S_IDLE : S_INIT;
            S_IDLE:  w_next = in_valid ? S_RD : S_IDLE;
            S_RD:    w_next = S_CMP;
            S_CMP:   w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_INIT;
        endcase
    end
    // Entry layout: {valid, status[1:0], key}.
    always_comb begin
        w_valid   = r_rd[KEY_SIZE+2];
        w_stat    = r_rd[KEY_SIZE +: 2];
        w_hit     = w_valid && r_rd[KEY_SIZE-1:0] == r_key;
        w_susp    = r_flag[0] && r_flag[2:1] == 2'b01;
        w_arr     = r_flag[0] && r_flag[2:1] == 2'b10;
        w_verdict = w_susp ? (w_hit && w_stat == 2'b10 ? 2'b10 : 2'b01) :
                    (w_arr && w_hit ? 2'b11 : 2'b00);
        // An unknown flow is never arrested, so ARREST only rewrites on a hit.
        w_wr      = (w_susp && !w_hit) || (w_arr && w_hit);
        w_evict   = w_susp && !w_hit && w_valid;
        w_wdata   = {1'b1, w_susp ? 2'b01 : 2'b10, r_key};
    end
    // Single port: the sweep owns the port during INIT, otherwise the captured index.
    assign w_we   = r_state == S_INIT || (r_state == S_RESP && r_wr);
    assign w_addr = r_state == S_INIT ? r_sweep : r_idx;
    assign w_wd   = r_state == S_INIT ? '0 : r_wdata;
    always_ff @(posedge clk156) begin
        if (w_we) r_mem[w_addr] <= w_wd;
        r_rd <= r_mem[w_addr];
    end
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            r_state     <= S_INIT;
            r_sweep     <= '0;
            r_idx       <= '0;
            r_key       <= '0;
            r_flag      <= '0;
            r_wr        <= 1'b0;
            r_wdata     <= '0;
            r_out_flag  <= '0;
            r_init_done <= 1'b0;
            r_hit       <= '0;
            r_drop      <= '0;
            r_evict     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_INIT) begin
                r_sweep <= r_sweep + 1'b1;
                if (&r_sweep) r_init_done <= 1'b1;
            end
            if (in_valid && in_ready) begin
                r_key  <= in_key;
                r_flag <= in_flag[2:0];
                r_idx  <= w_idx;
            end
            if (r_state == S_CMP) begin
                r_wr       <= w_wr;
                r_wdata    <= w_wdata;
                r_out_flag <= {1'b0, w_verdict, 1'b1};
                r_hit      <= r_hit + {15'd0, w_hit && r_hit != 16'hFFFF};
                r_evict    <= r_evict + {15'd0, w_evict && r_evict != 16'hFFFF};
            end
            r_drop <= r_drop + {15'd0, in_valid && !in_ready && r_drop != 16'hFFFF};
        end
    end
endmodule

// File: tb/tb_kv_filter_table.sv
// tb_kv_filter_table: directed vector table, corner sequences and randomized model check for kv_filter_table.
module tb_kv_filter_table;
    logic        clk156, eth_rst, in_valid, in_ready, out_valid, init_done;
    logic [95:0] in_key;
    logic [3:0]  in_flag, out_flag, got, exp;
    logic [15:0] hit_cnt, drop_cnt, evict_cnt;
    int          n_chk = 0, n_err = 0, n_resp = 0, d0;
    localparam logic [95:0] K = 96'hC0A80164_C0A80162_3039_0000;

    kv_filter_table dut (
        .clk156(clk156), .eth_rst(eth_rst), .in_key(in_key), .in_flag(in_flag),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_flag(out_flag),
        .init_done(init_done), .hit_cnt(hit_cnt), .drop_cnt(drop_cnt), .evict_cnt(evict_cnt)
    );

    initial begin
        clk156 = 1'b0;
        forever #5 clk156 = ~clk156;
    end
    always @(negedge clk156) if (out_valid) n_resp++;

    typedef struct {
        logic [95:0] key;
        logic [3:0]  flag;
        logic [3:0]  exp_flag;
        int          exp_hit;
        int          exp_evict;
    } vec_t;
    vec_t vt[9];

    bit          mv[64];
    logic [1:0]  ms[64];
    logic [95:0] mk[64];
    int          mhit, mev, mdrop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic release_and_sweep();
        int n;
        eth_rst = 1'b0;
        n = 0;
        while (!init_done && n < 200) begin
            @(posedge clk156); #1;
            n++;
        end
        chk("init_cycles", n, 64);
        chk("ready_after_init", 32'(in_ready), 1);
    endtask

    task automatic do_reset();
        eth_rst  = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk156);
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_flag", 32'(out_flag), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_hit_cnt", 32'(hit_cnt), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        chk("rst_evict_cnt", 32'(evict_cnt), 0);
        release_and_sweep();
    endtask

    task automatic req(input logic [95:0] key, input logic [3:0] flag, input bit dbl,
                       output logic [3:0] res);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk156); #1;
            n++;
        end
        chk("ready_wait", 32'(in_ready), 1);
        in_key   = key;
        in_flag  = flag;
        in_valid = 1'b1;
        @(posedge clk156); #1;
        n = 0;
        if (dbl) begin
            @(posedge clk156); #1;
            n = 1;
        end
        in_valid = 1'b0;
        while (!out_valid && n < 10) begin
            @(posedge clk156); #1;
            n++;
        end
        chk("latency", n, 2);
        res = out_flag;
        @(posedge clk156); #1;
        chk("resp_one_cycle", 32'(out_valid), 0);
        chk("ready_again", 32'(in_ready), 1);
    endtask

    function automatic int mhash(input logic [95:0] k);
        int h = 0;
        for (int i = 0; i < 16; i++) h = h ^ int'((k >> (6 * i)) & 96'h3F);
        return h;
    endfunction

    task automatic model(input logic [95:0] key, input logic [3:0] flag, output logic [3:0] e);
        int  i;
        bit  hit, s, a;
        logic [1:0] v;
        i   = mhash(key);
        hit = mv[i] && mk[i] == key;
        s   = flag[0] && flag[2:1] == 2'b01;
        a   = flag[0] && flag[2:1] == 2'b10;
        v   = 2'b00;
        if (hit) mhit++;
        if (s) begin
            if (hit) v = ms[i] == 2'b10 ? 2'b10 : 2'b01;
            else begin
                if (mv[i]) mev++;
                mv[i] = 1'b1;
                ms[i] = 2'b01;
                mk[i] = key;
                v = 2'b01;
            end
        end else if (a && hit) begin
            ms[i] = 2'b10;
            v = 2'b11;
        end
        e = {1'b0, v, 1'b1};
    endtask

    initial begin
        in_valid = 1'b0;
        in_key   = '0;
        in_flag  = '0;
        eth_rst  = 1'b0;
        vt[0] = '{K,        4'b0011, 4'b0011, 0, 0};
        vt[1] = '{K,        4'b0011, 4'b0011, 1, 0};
        vt[2] = '{K,        4'b0101, 4'b0111, 2, 0};
        vt[3] = '{K,        4'b0011, 4'b0101, 3, 0};
        vt[4] = '{96'h1234, 4'b0101, 4'b0001, 3, 0};
        vt[5] = '{96'h1234, 4'b0011, 4'b0011, 3, 0};
        vt[6] = '{96'h0,    4'b0011, 4'b0011, 3, 0};
        vt[7] = '{96'h41,   4'b0011, 4'b0011, 3, 1};
        vt[8] = '{96'h0,    4'b0101, 4'b0001, 3, 1};
        #2;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            req(vt[i].key, vt[i].flag, 1'b0, got);
            chk($sformatf("vec%0d_flag", i), 32'(got), 32'(vt[i].exp_flag));
            chk($sformatf("vec%0d_hit", i), 32'(hit_cnt), vt[i].exp_hit);
            chk($sformatf("vec%0d_evict", i), 32'(evict_cnt), vt[i].exp_evict);
        end
        d0 = n_resp;
        req(K, 4'b0011, 1'b1, got);
        chk("ovl_flag", 32'(got), 32'h5);
        chk("ovl_drop", 32'(drop_cnt), 1);
        repeat (4) @(posedge clk156);
        #1;
        chk("ovl_single_resp", n_resp - d0, 1);
        in_key   = K;
        in_flag  = 4'b0011;
        in_valid = 1'b1;
        @(posedge clk156); #1;
        in_valid = 1'b0;
        d0 = n_resp;
        eth_rst = 1'b1;
        #1;
        chk("rd_rst_out_valid", 32'(out_valid), 0);
        chk("rd_rst_init_done", 32'(init_done), 0);
        chk("rd_rst_hit_cnt", 32'(hit_cnt), 0);
        repeat (5) @(posedge clk156);
        #1;
        chk("rd_rst_no_resp", n_resp - d0, 0);
        release_and_sweep();
        req(K, 4'b0011, 1'b0, got);
        chk("after_rst_cleared", 32'(got), 32'h3);
        chk("after_rst_hit", 32'(hit_cnt), 0);
        do_reset();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        mhit = 0;
        mev = 0;
        mdrop = 0;
        for (int t = 0; t < 300; t++) begin
            logic [95:0] k;
            logic [3:0]  f;
            bit          dbl;
            k   = 96'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) k = K ^ 96'($urandom_range(0, 3));
            f   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) f[0] = 1'b1;
            dbl = $urandom_range(0, 7) == 0;
            if (dbl) mdrop++;
            model(k, f, exp);
            req(k, f, dbl, got);
            chk($sformatf("rand%0d_flag", t), 32'(got), 32'(exp));
        end
        chk("rand_hit_cnt", 32'(hit_cnt), mhit);
        chk("rand_evict_cnt", 32'(evict_cnt), mev);
        chk("rand_drop_cnt", 32'(drop_cnt), mdrop);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
